// File: rtl/calc_hist.sv
// Accumulator calculator: ALU driven by edge-detected buttons, with an optional
// undo LIFO that is built only when CALC_UNDO_EN is defined.
module calc_hist #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             btnu,
  input  logic             btnd,
  input  logic             btn_undo,
  input  logic             btnl,
  input  logic             btnc,
  input  logic             btnr,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] led,
  output logic             zero,
  output logic             ovf,
  output logic [CW-1:0]    hist_cnt
);

  logic             btnd_q;
  logic             exe;
  logic [2:0]       op;
  logic [WIDTH-1:0] res;
  logic             res_ovf;

  assign exe  = btnd & ~btnd_q;
  assign op   = {btnl, btnc, btnr};
  assign zero = (led == '0);

  // Shift amounts past WIDTH fall out naturally: << gives 0, >>> gives sign fill.
  always_comb begin
    res     = '0;
    res_ovf = 1'b0;
    unique case (op)
      3'b000: begin
        res     = led + sw;
        res_ovf = (led[WIDTH-1] == sw[WIDTH-1]) && (res[WIDTH-1] != led[WIDTH-1]);
      end
      3'b001: begin
        res     = led - sw;
        res_ovf = (led[WIDTH-1] != sw[WIDTH-1]) && (res[WIDTH-1] != led[WIDTH-1]);
      end
      3'b010: res = led & sw;
      3'b011: res = led | sw;
      3'b100: res = led ^ sw;
      3'b101: res = led << sw[3:0];
      3'b110: res = WIDTH'($signed(led) >>> sw[3:0]);
      3'b111: res = ~(led | sw);
    endcase
  end

`ifdef CALC_UNDO_EN
  logic                        undo_q;
  logic                        pop;
  logic [DEPTH-1:0][WIDTH-1:0] hist;

  // Execute wins over a coincident undo; popping an empty stack is a no-op.
  assign pop = btn_undo & ~undo_q & ~exe & (hist_cnt != '0);

  always_ff @(posedge clk) begin
    if (btnu) begin
      undo_q   <= 1'b1;
      hist_cnt <= '0;
    end else begin
      undo_q <= btn_undo;
      if (exe) begin
        if (hist_cnt != CW'(DEPTH)) hist_cnt <= hist_cnt + 1'b1;
      end else if (pop) begin
        hist_cnt <= hist_cnt - 1'b1;
      end
    end
  end

  // hist[0] is the newest entry; a full push shifts the oldest off the end.
  always_ff @(posedge clk) begin
    if (!btnu && exe) begin
      for (int i = DEPTH - 1; i > 0; i--) hist[i] <= hist[i-1];
      hist[0] <= led;
    end else if (!btnu && pop) begin
      for (int i = 0; i < DEPTH - 1; i++) hist[i] <= hist[i+1];
    end
  end
`else
  logic unused_undo;
  assign unused_undo = btn_undo;
  assign hist_cnt    = '0;
`endif

  always_ff @(posedge clk) begin
    if (btnu) begin
      led    <= '0;
      ovf    <= 1'b0;
      btnd_q <= 1'b1;
    end else begin
      btnd_q <= btnd;
      if (exe) begin
        led <= res;
        ovf <= res_ovf;
      end
`ifdef CALC_UNDO_EN
      else if (pop) begin
        led <= hist[0];
        ovf <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_calc_hist.sv
// Directed bench for calc_hist; expectations follow whether CALC_UNDO_EN is defined.
module tb_calc_hist;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
`ifdef CALC_UNDO_EN
  localparam bit UNDO = 1'b1;
`else
  localparam bit UNDO = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             btnu = 1'b1, btnd = 1'b0, btn_undo = 1'b0;
  logic             btnl = 1'b0, btnc = 1'b0, btnr = 1'b0;
  logic [WIDTH-1:0] sw = '0;
  logic [WIDTH-1:0] led;
  logic             zero, ovf;
  logic [CW-1:0]    hist_cnt;

  int errs   = 0;
  int checks = 0;

  calc_hist #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .btnu(btnu), .btnd(btnd), .btn_undo(btn_undo),
    .btnl(btnl), .btnc(btnc), .btnr(btnr), .sw(sw),
    .led(led), .zero(zero), .ovf(ovf), .hist_cnt(hist_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [2:0] o, input logic [WIDTH-1:0] v);
    {btnl, btnc, btnr} = o;
    sw = v;
  endtask

  task automatic press(input logic [2:0] o, input logic [WIDTH-1:0] v);
    set_op(o, v);
    btnd = 1'b1;
    tick();
    btnd = 1'b0;
    tick();
  endtask

  task automatic undo();
    btn_undo = 1'b1;
    tick();
    btn_undo = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    btnu = 1'b1;
    tick();
    tick();
    btnu = 1'b0;
    tick();
  endtask

  initial begin
    // reset state
    tick();
    tick();
    chk("rst_led", led, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_cnt", hist_cnt, 0);
    chk("rst_zero", zero, 1);
    btnu = 1'b0;
    tick();

    // one update per press regardless of hold length
    set_op(3'b000, 16'd5);
    btnd = 1'b1;
    tick();
    chk("hold_first", led, 16'h0005);
    repeat (9) tick();
    chk("hold_stay", led, 16'h0005);
    chk("hold_zero", zero, 0);
    chk("hold_cnt", hist_cnt, UNDO ? 1 : 0);
    btnd = 1'b0;
    tick();

    // op coverage
    press(3'b001, 16'd7);     chk("sub", led, 16'hFFFE);
    chk("sub_ovf", ovf, 0);
    press(3'b110, 16'd1);     chk("sra1", led, 16'hFFFF);
    press(3'b101, 16'd4);     chk("sll4", led, 16'hFFF0);
    press(3'b100, 16'h0FF0);  chk("xor", led, 16'hF000);
    press(3'b011, 16'h000F);  chk("or", led, 16'hF00F);
    press(3'b111, 16'h0F00);  chk("nor", led, 16'h00F0);
    press(3'b010, 16'h0000);  chk("and0", led, 16'h0000);
    press(3'b000, 16'h7FFF);  chk("add_max", led, 16'h7FFF);
    chk("add_max_ovf", ovf, 0);
    press(3'b000, 16'h0001);  chk("add_ovf_led", led, 16'h8000);
    chk("add_ovf", ovf, 1);
    press(3'b010, 16'h0000);  chk("and_clr_led", led, 16'h0000);
    chk("and_clr_ovf", ovf, 0);
    chk("and_clr_zero", zero, 1);
    press(3'b000, 16'h8000);  press(3'b001, 16'h8000);
    chk("sub_ovf_led", led, 16'h0000);
    chk("sub_ovf_flag", ovf, 0);
    press(3'b001, 16'h8000);  chk("sub_min_led", led, 16'h8000);
    chk("sub_min_ovf", ovf, 1);
    press(3'b110, 16'd15);    chk("sra15", led, 16'hFFFF);
    chk("sra_ovf_clr", ovf, 0);
    press(3'b101, 16'd15);    chk("sll15", led, 16'h8000);
    press(3'b101, 16'h0010);  chk("sll_low4", led, 16'h8000);

    // history fill, saturation, and pops down past empty
    do_reset();
    for (int i = 0; i < 5; i++) press(3'b000, 16'd1);
    chk("fill_led", led, 5);
    chk("fill_cnt", hist_cnt, UNDO ? 4 : 0);
    for (int i = 0; i < 5; i++) begin
      undo();
      chk($sformatf("undo%0d_led", i), led, UNDO ? ((i < 4) ? 4 - i : 1) : 5);
      chk($sformatf("undo%0d_cnt", i), hist_cnt, UNDO ? ((i < 4) ? 3 - i : 0) : 0);
    end

    // coincident execute and undo: execute wins
    do_reset();
    press(3'b000, 16'd3);
    set_op(3'b000, 16'd2);
    btnd = 1'b1;
    btn_undo = 1'b1;
    tick();
    chk("coinc_led", led, 5);
    chk("coinc_cnt", hist_cnt, UNDO ? 2 : 0);
    btnd = 1'b0;
    btn_undo = 1'b0;
    tick();
    undo();
    chk("coinc_undo_led", led, UNDO ? 3 : 5);
    chk("coinc_undo_ovf", ovf, 0);

    // reset while execute is held
    set_op(3'b000, 16'h7FFF);
    btnd = 1'b1;
    tick();
    chk("pre_rst_ovf", ovf, 1);
    btnu = 1'b1;
    tick();
    chk("hrst_led", led, 0);
    chk("hrst_ovf", ovf, 0);
    chk("hrst_cnt", hist_cnt, 0);
    btnu = 1'b0;
    repeat (3) tick();
    chk("hrst_nofire", led, 0);
    btnd = 1'b0;
    tick();
    press(3'b000, 16'd2);
    chk("hrst_refire", led, 2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
